// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide execution unit.
//
// Accepts one operation in IDLE and returns a sign-corrected result with
// its destination tag on a one-cycle done pulse.
// - Multiply: radix-2 shift-add, one bit per cycle.
// - Divide: restoring division, one quotient bit per cycle.
// - Divide by zero and signed overflow are resolved at capture and skip
//   the iteration.
//
// Ports:
//   clk, reset       clock; asynchronous active-high reset
//   start, op        request and RV32M funct3 (sampled only in IDLE)
//   rs1_val, rs2_val operands A (dividend/multiplicand), B (divisor/multiplier)
//   rd_in            destination tag, captured with the operands
//   kill             flush: aborts an in-flight operation, no done
//   busy             high while an accepted operation is in flight
//   done             one-cycle result-valid pulse
//   result, rd_out   final value and tag, held until the next done
//
// Build option: define MULDIV_FAST_MUL_EN to compute multiplies in a single
// cycle with a combinational multiplier at capture. Divide is unchanged.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIN = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] result_q;
  logic [4:0]      rd_q;

  // Datapath registers: a_q holds the multiplicand or the divisor.
  // {hi_q, lo_q} is the product accumulator or the remainder/quotient pair.
  logic [XLEN-1:0] a_q, hi_q, lo_q, hi_d, lo_d;
  logic [2:0]      op_q;
  logic [4:0]      tag_q;
  logic            qneg_q, rneg_q, direct_q;

  logic            accept, commit;
  logic            is_div, a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, direct;
  logic [XLEN-1:0] direct_val;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN-1:0] div_diff;
  logic            div_ge;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0] quo_s, rem_s, fin_val;

  // Operand signedness and magnitudes. MULHSU treats only rs1 as signed.
  always_comb begin
    is_div   = op[2];
    a_sgn    = is_div ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
    b_sgn    = is_div ? ~op[0] : (op[1:0] == 2'b01);
    a_neg    = a_sgn & rs1_val[XLEN-1];
    b_neg    = b_sgn & rs2_val[XLEN-1];
    a_mag    = a_neg ? -rs1_val : rs1_val;
    b_mag    = b_neg ? -rs2_val : rs2_val;
    div_zero = is_div & (rs2_val == '0);
    div_ovf  = is_div & ~op[0] & (rs1_val == SMIN) & (rs2_val == '1);
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fa, fb, fprod;
  always_comb begin
    fa    = {{XLEN{a_neg}}, rs1_val};
    fb    = {{XLEN{b_neg}}, rs2_val};
    fprod = fa * fb;
    direct = div_zero | div_ovf | ~is_div;
    if (!is_div)
      direct_val = (op[1:0] == 2'b00) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
    else if (div_zero)
      direct_val = op[1] ? rs1_val : '1;
    else
      direct_val = op[1] ? '0 : SMIN;
  end
`else
  always_comb begin
    direct = div_zero | div_ovf;
    if (div_zero)
      direct_val = op[1] ? rs1_val : '1;
    else
      direct_val = op[1] ? '0 : SMIN;
  end
`endif

  // One iteration step: add-and-shift for multiply, shift-and-trial-subtract
  // for divide. The modular XLEN-bit difference is exact whenever div_ge holds.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, a_q});
    div_diff  = div_shift[XLEN-1:0] - a_q;
    if (op_q[2]) begin
      hi_d = div_ge ? div_diff : div_shift[XLEN-1:0];
      lo_d = {lo_q[XLEN-2:0], div_ge};
    end else begin
      {hi_d, lo_d} = {mul_sum, lo_q[XLEN-1:1]};
    end
  end

  // Sign correction, evaluated while in FIN.
  always_comb begin
    prod_s = qneg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    quo_s  = qneg_q ? -lo_q : lo_q;
    rem_s  = rneg_q ? -hi_q : hi_q;
    if (direct_q)
      fin_val = lo_q;
    else if (!op_q[2])
      fin_val = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    else
      fin_val = op_q[1] ? rem_s : quo_s;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !kill) begin
          accept  = 1'b1;
          cnt_d   = CNT_LAST;
          state_d = direct ? FIN : CALC;
        end
      end
      CALC: begin
        if (kill)
          state_d = IDLE;
        else if (cnt_q == '0)
          state_d = FIN;
        else
          cnt_d = cnt_q - CW'(1);
      end
      FIN: begin
        state_d = IDLE;
        commit  = ~kill;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: the new result is visible during the done cycle and is latched
  // at its closing edge; a kill in FIN suppresses both.
  always_comb begin
    busy   = (state_q != IDLE);
    done   = (state_q == FIN) & ~kill;
    result = done ? fin_val : result_q;
    rd_out = done ? tag_q : rd_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (commit) begin
        result_q <= fin_val;
        rd_q     <= tag_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_q     <= op;
      tag_q    <= rd_in;
      qneg_q   <= a_neg ^ b_neg;
      rneg_q   <= a_neg;
      direct_q <= direct;
      a_q      <= is_div ? b_mag : a_mag;
      hi_q     <= '0;
      lo_q     <= direct ? direct_val : (is_div ? a_mag : b_mag);
    end else if (state_q == CALC) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed testbench for muldiv_unit (XLEN = 32).
// An arithmetic reference model predicts the result and latency of each
// operation. A single compare process checks busy/done/result/rd_out on
// every negative clock edge against the predicted timeline.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, start, kill;
  logic [2:0]  op;
  logic [31:0] rs1_val, rs2_val;
  logic [4:0]  rd_in;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in), .kill(kill),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Expected timeline shared between driver and compare process.
  bit          exp_active = 1'b0;
  int          exp_cnt, exp_lat;
  logic [31:0] exp_res;
  logic [4:0]  exp_rd;
  logic [31:0] last_res = '0;
  logic [4:0]  last_rd = '0;
  string       exp_name = "";

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, expv);
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint sa, sb;
    int q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      default: begin
        if (b == 32'd0) return o[1] ? a : 32'hFFFFFFFF;
        if (!o[0]) begin
          if (a == 32'h80000000 && b == 32'hFFFFFFFF) return o[1] ? 32'd0 : 32'h80000000;
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
          return o[1] ? r : q;
        end
        return o[1] ? (a % b) : (a / b);
      end
    endcase
  endfunction

  function automatic int lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2])
      return (b == 32'd0 || (!o[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)) ? 1 : 33;
`ifdef MULDIV_FAST_MUL_EN
    return 1;
`else
    return 33;
`endif
  endfunction

  // Compare process.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset done", {31'b0, done}, 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset rd_out", {27'b0, rd_out}, 32'd0);
      end else if (exp_active) begin
        exp_cnt++;
        chk({exp_name, " busy"}, {31'b0, busy}, 32'd1);
        if (exp_cnt == exp_lat) begin
          chk({exp_name, " done"}, {31'b0, done}, 32'd1);
          chk({exp_name, " result"}, result, exp_res);
          chk({exp_name, " rd_out"}, {27'b0, rd_out}, {27'b0, exp_rd});
          last_res   = exp_res;
          last_rd    = exp_rd;
          exp_active = 1'b0;
        end else begin
          chk({exp_name, " early done"}, {31'b0, done}, 32'd0);
          chk({exp_name, " held result"}, result, last_res);
        end
      end else begin
        chk("idle busy", {31'b0, busy}, 32'd0);
        chk("idle done", {31'b0, done}, 32'd0);
        chk("idle result", result, last_res);
        chk("idle rd_out", {27'b0, rd_out}, {27'b0, last_rd});
      end
    end
  end

  // Drive one request (called #1 after a posedge with the DUT idle) and
  // register its expected outcome; lit is the hand-computed result.
  task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] lit, input string nm, input bit hold);
    chk({nm, " model"}, model(o, a, b), lit);
    op = o; rs1_val = a; rs2_val = b; rd_in = rd; start = 1'b1;
    @(posedge clk); #1;
    exp_name   = nm;
    exp_cnt    = 0;
    exp_lat    = lat(o, a, b);
    exp_res    = lit;
    exp_rd     = rd;
    exp_active = 1'b1;
    if (!hold) start = 1'b0;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] lit, input string nm, input bit hold);
    int k;
    launch(o, a, b, rd, lit, nm, hold);
    k = 0;
    while (exp_active && k < 80) begin
      @(negedge clk);
      k++;
    end
    if (exp_active) begin
      n_chk++;
      $display("FAIL %s timeout: no done after %0d cycles, required within %0d", nm, k, exp_lat);
      exp_active = 1'b0;
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; kill = 1'b0;
    op = '0; rs1_val = '0; rs2_val = '0; rd_in = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    issue(3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, "MUL 7*-3", 1'b0);
    issue(3'd1, 32'h80000000, 32'h80000000, 5'd1, 32'h40000000, "MULH min*min", 1'b0);
    issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, "MULHU", 1'b0);
    issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFF, "MULHSU -1", 1'b0);
    issue(3'd2, 32'h80000000, 32'h80000000, 5'd4, 32'hC0000000, "MULHSU min", 1'b0);
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 32'h00000000, "MULH -1*-1", 1'b0);
    issue(3'd0, 32'h12345678, 32'h00000010, 5'd7, 32'h23456780, "MUL shift", 1'b0);
    issue(3'd4, 32'hFFFFFFF9, 32'd2, 5'd8, 32'hFFFFFFFD, "DIV -7/2", 1'b0);
    issue(3'd6, 32'hFFFFFFF9, 32'd2, 5'd9, 32'hFFFFFFFF, "REM -7/2", 1'b0);
    issue(3'd5, 32'd100, 32'd7, 5'd10, 32'd14, "DIVU 100/7", 1'b0);
    issue(3'd7, 32'd100, 32'd7, 5'd11, 32'd2, "REMU 100/7", 1'b0);
    issue(3'd4, 32'd7, 32'hFFFFFFFE, 5'd12, 32'hFFFFFFFD, "DIV 7/-2", 1'b0);
    issue(3'd6, 32'd7, 32'hFFFFFFFE, 5'd13, 32'd1, "REM 7/-2", 1'b0);
    issue(3'd5, 32'hFFFFFFFF, 32'h10, 5'd14, 32'h0FFFFFFF, "DIVU big", 1'b0);
    issue(3'd7, 32'hFFFFFFFF, 32'h10, 5'd15, 32'h0000000F, "REMU big", 1'b0);
    issue(3'd4, 32'h80000000, 32'd2, 5'd16, 32'hC0000000, "DIV min/2", 1'b0);
    issue(3'd5, 32'hDEADBEEF, 32'd0, 5'd17, 32'hFFFFFFFF, "DIVU x/0", 1'b0);
    issue(3'd6, 32'h00001234, 32'd0, 5'd18, 32'h00001234, "REM x/0", 1'b0);
    issue(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'h80000000, "DIV ovf", 1'b0);
    issue(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd20, 32'h00000000, "REM ovf", 1'b0);

    // Kill during CALC: asserted in cycle T+10, IDLE at T+11, no done.
    launch(3'd4, 32'd1000, 32'd3, 5'd21, 32'd333, "DIV killed", 1'b0);
    repeat (9) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    exp_active = 1'b0;
    issue(3'd4, 32'd1000, 32'd3, 5'd22, 32'd333, "DIV after kill", 1'b0);

    // Kill together with start in IDLE: request dropped.
    op = 3'd5; rs1_val = 32'd9; rs2_val = 32'd3; rd_in = 5'd23;
    start = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Start held high for the whole operation: exactly one done.
    issue(3'd7, 32'd50, 32'd8, 5'd24, 32'd2, "REMU held start", 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-operation clears outputs immediately.
    launch(3'd0, 32'd3, 32'd5, 5'd25, 32'd15, "MUL reset", 1'b0);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_active = 1'b0;
    last_res = '0;
    last_rd = '0;
    #1;
    chk("async reset busy", {31'b0, busy}, 32'd0);
    chk("async reset done", {31'b0, done}, 32'd0);
    chk("async reset result", result, 32'd0);
    chk("async reset rd_out", {27'b0, rd_out}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    issue(3'd0, 32'd3, 32'd5, 5'd26, 32'd15, "MUL after reset", 1'b0);
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
